ro_measure_seq: RTL

Measurement sequencer for the ring-oscillator test array. On one `start` it serially loads the oscillator configuration shift chain, selects an oscillator and enables it. After a settle delay it counts rising edges of the selected (divided) oscillator output over a programmable window of `clk` cycles and reports the count. It replaces manual bit-banging of `shift_clk`/`shift_dta`/`clk_source` from the pads.

---
 rtl/ro_measure_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ro_measure_seq.sv
// Ring-oscillator measurement sequencer: loads the config chain, enables the selected
// oscillator, then counts its edges over a gate window. Optional readback: RO_MEAS_READBACK_EN.
module ro_measure_seq #(
   parameter int CFG_BITS   = 12,
   parameter int SETTLE_CYC = 16,
   parameter int CNT_W      = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [CFG_BITS-1:0] cfg_word,
   input  logic [2:0]          src_sel,
   input  logic [15:0]         gate_len,
   input  logic                ro_clk,
   input  logic                shift_tail,
   output logic                shift_clk,
   output logic                shift_dta,
   output logic [2:0]          clk_source,
   output logic                osc_en,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    count,
   output logic                overflow,
   output logic                cfg_err
);

   localparam int IDX_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

   typedef enum logic [2:0] {IDLE, SHIFT, SETTLE, GATE, DONE} state_t;

   state_t              state_r;
   logic [CFG_BITS-1:0] cfg_r;
   logic [IDX_W-1:0]    idx_r;
   logic                phase_b_r;
   logic [15:0]         tmr_r;
   logic [15:0]         gate_r;
   logic                ro_s1_r, ro_s2_r, ro_s3_r;
   logic                edge_s;

   assign edge_s = ro_s2_r & ~ro_s3_r;

   // ro_clk synchronizer plus edge-detect history flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ro_s1_r <= 1'b0;
         ro_s2_r <= 1'b0;
         ro_s3_r <= 1'b0;
      end else begin
         ro_s1_r <= ro_clk;
         ro_s2_r <= ro_s1_r;
         ro_s3_r <= ro_s2_r;
      end
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         cfg_r      <= {CFG_BITS{1'b0}};
         idx_r      <= {IDX_W{1'b0}};
         phase_b_r  <= 1'b0;
         tmr_r      <= 16'd0;
         gate_r     <= 16'd0;
         shift_clk  <= 1'b0;
         shift_dta  <= 1'b0;
         clk_source <= 3'd0;
         osc_en     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         count      <= {CNT_W{1'b0}};
         overflow   <= 1'b0;
      end else if (abort && (state_r != IDLE)) begin
         state_r   <= IDLE;
         busy      <= 1'b0;
         osc_en    <= 1'b0;
         shift_clk <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start && !abort) begin
                  state_r    <= SHIFT;
                  busy       <= 1'b1;
                  cfg_r      <= cfg_word;
                  gate_r     <= gate_len;
                  clk_source <= src_sel;
                  count      <= {CNT_W{1'b0}};
                  overflow   <= 1'b0;
                  idx_r      <= IDX_W'(CFG_BITS - 1);
                  phase_b_r  <= 1'b0;
                  shift_clk  <= 1'b0;
                  shift_dta  <= cfg_word[CFG_BITS-1];
               end
            end
            SHIFT: begin
               if (!phase_b_r) begin
                  phase_b_r <= 1'b1;
                  shift_clk <= 1'b1;
               end else if (idx_r == {IDX_W{1'b0}}) begin
                  phase_b_r <= 1'b0;
                  shift_clk <= 1'b0;
                  osc_en    <= 1'b1;
                  tmr_r     <= 16'(SETTLE_CYC - 1);
                  state_r   <= SETTLE;
               end else begin
                  phase_b_r <= 1'b0;
                  shift_clk <= 1'b0;
                  shift_dta <= cfg_r[idx_r - IDX_W'(1)];
                  idx_r     <= idx_r - IDX_W'(1);
               end
            end
            SETTLE: begin
               if (tmr_r != 16'd0) begin
                  tmr_r <= tmr_r - 16'd1;
               end else if (gate_r == 16'd0) begin
                  osc_en  <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  tmr_r   <= gate_r - 16'd1;
                  state_r <= GATE;
               end
            end
            GATE: begin
               if (edge_s) begin
                  if (count == {CNT_W{1'b1}}) begin
                     overflow <= 1'b1;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
               if (tmr_r != 16'd0) begin
                  tmr_r <= tmr_r - 16'd1;
               end else begin
                  osc_en  <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r   <= IDLE;
               busy      <= 1'b0;
               osc_en    <= 1'b0;
               shift_clk <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

`ifdef RO_MEAS_READBACK_EN
   logic [CFG_BITS-1:0] rb_r;
   logic [CFG_BITS-1:0] prev_r;
   logic                prev_vld_r;

   // Readback capture in Phase A; compare against previous load at SHIFT exit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rb_r       <= {CFG_BITS{1'b0}};
         prev_r     <= {CFG_BITS{1'b0}};
         prev_vld_r <= 1'b0;
         cfg_err    <= 1'b0;
      end else if (state_r == SHIFT) begin
         if (abort) begin
            prev_vld_r <= 1'b0;
         end else if (!phase_b_r) begin
            rb_r <= {rb_r[CFG_BITS-2:0], shift_tail};
         end else if (idx_r == {IDX_W{1'b0}}) begin
            cfg_err    <= prev_vld_r && (rb_r != prev_r);
            prev_r     <= cfg_r;
            prev_vld_r <= 1'b1;
         end else begin
            rb_r <= rb_r;
         end
      end else begin
         rb_r <= rb_r;
      end
   end
`else
   logic unused_tail_s;
   assign unused_tail_s = shift_tail;
   assign cfg_err       = 1'b0;
`endif

endmodule
